// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sample_fifo
//  Description : Sample FIFO between an audio producer and a DAC serializer.
//                Samples are popped on the rising edge of the serializer's
//                done pulse. The block also provides mute, flush, occupancy
//                level and underrun status (sticky flag and saturating count).
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       AUD_BCLK,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       dac_done,
    output logic [DATA_W-1:0]          sample_out,
    input  logic                       mute,
    input  logic                       flush,
    input  logic                       clear_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun,
    output logic [7:0]                 underrun_count
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);
    localparam logic [7:0]      C_USAT = 8'd255;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              urun_q,   urun_d;
    logic [7:0]        ucnt_q,   ucnt_d;
    // Previous value of dac_done; resets high so a level already high at
    // reset release is not mistaken for a fresh done edge.
    logic              dac_done_prev_q;

    logic pop_ev;
    logic wr_acc;
    logic empty;
    logic pop_ok;
    logic urun_ev;

    assign in_ready       = (count_q != C_FULL);
    assign level          = count_q;
    assign sample_out     = sample_q;
    assign underrun       = urun_q;
    assign underrun_count = ucnt_q;

    // Next-state computation: flush overrides traffic, underrun beats clear.
    always_comb begin
        pop_ev   = dac_done & ~dac_done_prev_q;
        wr_acc   = in_valid & in_ready;
        empty    = (count_q == '0);
        pop_ok   = pop_ev & ~empty & ~flush;
        urun_ev  = pop_ev & empty & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sample_d = sample_q;
        urun_d   = urun_q;
        ucnt_d   = ucnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sample_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                sample_d = mute ? '0 : mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else if (pop_ev) begin
                sample_d = '0;
            end
            case ({wr_acc, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        if (urun_ev) begin
            urun_d = 1'b1;
            if (clear_flags) begin
                ucnt_d = 8'd1;
            end else if (ucnt_q != C_USAT) begin
                ucnt_d = ucnt_q + 8'd1;
            end
        end else if (clear_flags) begin
            urun_d = 1'b0;
            ucnt_d = 8'd0;
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge AUD_BCLK) begin
        if (!rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            sample_q        <= '0;
            urun_q          <= 1'b0;
            ucnt_q          <= 8'd0;
            dac_done_prev_q <= 1'b1;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            sample_q        <= sample_d;
            urun_q          <= urun_d;
            ucnt_q          <= ucnt_d;
            dac_done_prev_q <= dac_done;
        end
    end

    // Sample storage; contents need no reset since count gates every read.
    always_ff @(posedge AUD_BCLK) begin
        if (rst && !flush && wr_acc) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
`default_nettype wire
